// File: rtl/ps_alu_stat_pkg.sv
// ps_alu_stat_pkg: shared constants and types for the program-sequencer ALU
// status block. This package holds the condition codes, the ASTAT bit
// positions, the opcode field positions, the COMP opcode and the flag struct.
package ps_alu_stat_pkg;

    // Condition codes evaluated against the effective flags
    localparam logic [3:0] CC_EQ    = 4'd0;
    localparam logic [3:0] CC_NE    = 4'd1;
    localparam logic [3:0] CC_LT    = 4'd2;
    localparam logic [3:0] CC_GE    = 4'd3;
    localparam logic [3:0] CC_LE    = 4'd4;
    localparam logic [3:0] CC_GT    = 4'd5;
    localparam logic [3:0] CC_AC    = 4'd6;
    localparam logic [3:0] CC_NAC   = 4'd7;
    localparam logic [3:0] CC_AV    = 4'd8;
    localparam logic [3:0] CC_NAV   = 4'd9;
    localparam logic [3:0] CC_TRUE  = 4'd10;
    localparam logic [3:0] CC_FALSE = 4'd11;

    // ASTAT bit indices, register layout is {av, ac, an, az}
    localparam int ASTAT_AZ = 0;
    localparam int ASTAT_AN = 1;
    localparam int ASTAT_AC = 2;
    localparam int ASTAT_AV = 3;

    // Opcode field positions, opcode layout is {log, hc[1:0], sc[2:0]}
    localparam int OP_LOG    = 5;
    localparam int OP_HC_LSB = 3;
    localparam int OP_SC_LSB = 0;

    localparam logic [5:0] OP_COMP = 6'b000101;

    // Bit order matches the ASTAT layout, so a flags_t casts directly to/from ps_astat
    typedef struct packed {
        logic av;
        logic ac;
        logic an;
        logic az;
    } flags_t;

endpackage

// File: rtl/ps_alu_stat_if.sv
// ps_alu_stat_if: ALU control/flag bus between the program sequencer and the ALU.
//   master (sequencer): drives ps_alu_* controls and receives alu_ps_* flags
//   slave  (ALU)      : receives the controls and drives back the flags
//   The flags are valid in the cycle after an instruction issues.
interface ps_alu_stat_if;
    logic       ps_alu_en;
    logic       ps_alu_log;
    logic [1:0] ps_alu_hc;
    logic [2:0] ps_alu_sc;
    logic       ps_alu_sat;
    logic       ps_alu_ci;
    logic       alu_ps_az;
    logic       alu_ps_an;
    logic       alu_ps_ac;
    logic       alu_ps_av;
    logic       alu_ps_compd;

    modport master (
        output ps_alu_en, ps_alu_log, ps_alu_hc, ps_alu_sc, ps_alu_sat, ps_alu_ci,
        input  alu_ps_az, alu_ps_an, alu_ps_ac, alu_ps_av, alu_ps_compd
    );

    modport slave (
        input  ps_alu_en, ps_alu_log, ps_alu_hc, ps_alu_sc, ps_alu_sat, ps_alu_ci,
        output alu_ps_az, alu_ps_an, alu_ps_ac, alu_ps_av, alu_ps_compd
    );
endinterface

// File: rtl/ps_alu_stat_cond_eval.sv
// ps_cond_eval: combinational branch condition evaluation.
//   flags     in  effective {av, ac, an, az}
//   code      in  4-bit condition code, where 12-15 are reserved and evaluate false
//   cond_true out condition result
module ps_cond_eval
    import ps_alu_stat_pkg::*;
(
    input  flags_t     flags,
    input  logic [3:0] code,
    output logic       cond_true
);

    always_comb begin
        cond_true = 1'b0;
        case (code)
            CC_EQ:    cond_true = flags.az;
            CC_NE:    cond_true = ~flags.az;
            CC_LT:    cond_true = flags.an;
            CC_GE:    cond_true = ~flags.an;
            CC_LE:    cond_true = flags.an | flags.az;
            CC_GT:    cond_true = ~(flags.an | flags.az);
            CC_AC:    cond_true = flags.ac;
            CC_NAC:   cond_true = ~flags.ac;
            CC_AV:    cond_true = flags.av;
            CC_NAV:   cond_true = ~flags.av;
            CC_TRUE:  cond_true = 1'b1;
            CC_FALSE: cond_true = 1'b0;
            default:  cond_true = 1'b0;
        endcase
    end

endmodule

// File: rtl/ps_alu_stat.sv
// ps_alu_stat: program-sequencer side of the ALU control/flag interface.
// The block drives the ALU controls for each decoded instruction and captures
// the returned flags into ASTAT one cycle later. It also keeps the sticky
// overflow flag, the COMP history and the MODE1 saturation bit, and it
// evaluates branch conditions with in-flight flags forwarded.
//   clk, reset     clock, synchronous active-high reset
//   id_alu_vld/op  decoded ALU instruction and its {log, hc, sc} opcode
//   alu            ALU control/flag bus (master side)
//   ps_stat_wr/din explicit ASTAT write {av, ac, an, az}
//   ps_mode_wr/din MODE1 saturation-bit write
//   ps_stky_clr    clear the sticky AV flag
//   ps_cond_code   condition to evaluate, ps_cond_true is its result
//   ps_astat, ps_stky_av, ps_cmp_hist  status outputs (history newest in [1:0])
module ps_alu_stat
    import ps_alu_stat_pkg::*;
#(
    parameter int HIST_DEPTH = 4
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    id_alu_vld,
    input  logic [5:0]              id_alu_op,
    ps_alu_stat_if.master           alu,
    input  logic                    ps_stat_wr,
    input  logic [3:0]              ps_stat_din,
    input  logic                    ps_mode_wr,
    input  logic                    ps_mode_din,
    input  logic                    ps_stky_clr,
    input  logic [3:0]              ps_cond_code,
    output logic                    ps_cond_true,
    output logic [3:0]              ps_astat,
    output logic                    ps_stky_av,
    output logic [2*HIST_DEPTH-1:0] ps_cmp_hist
);

    logic   flag_pend;  // an instruction issued last cycle, so its flags are on alu_ps_* now
    logic   sat_q;
    flags_t live_flags;
    flags_t eff_flags;
    logic   stky_set;

    // Controls are a straight decode of the instruction being issued this cycle
    assign alu.ps_alu_en  = id_alu_vld;
    assign alu.ps_alu_log = id_alu_op[OP_LOG];
    assign alu.ps_alu_hc  = id_alu_op[OP_HC_LSB +: 2];
    assign alu.ps_alu_sc  = id_alu_op[OP_SC_LSB +: 3];
    assign alu.ps_alu_sat = sat_q;

    assign live_flags = '{av: alu.alu_ps_av, ac: alu.alu_ps_ac,
                          an: alu.alu_ps_an, az: alu.alu_ps_az};

    // While flags are in flight, ASTAT is stale, so consumers see the ALU outputs instead
    assign eff_flags     = flag_pend ? live_flags : flags_t'(ps_astat);
    assign alu.ps_alu_ci = eff_flags.ac;

    ps_cond_eval u_cond_eval (
        .flags     (eff_flags),
        .code      (ps_cond_code),
        .cond_true (ps_cond_true)
    );

    assign stky_set = (flag_pend & alu.alu_ps_av) | (ps_stat_wr & ps_stat_din[ASTAT_AV]);

    always_ff @(posedge clk) begin
        if (reset) begin
            flag_pend   <= 1'b0;
            ps_astat    <= '0;
            ps_stky_av  <= 1'b0;
            ps_cmp_hist <= '0;
            sat_q       <= 1'b0;
        end else begin
            flag_pend <= id_alu_vld;

            // An explicit write belongs to the younger instruction, so it overrides a capture
            if (ps_stat_wr)
                ps_astat <= ps_stat_din;
            else if (flag_pend)
                ps_astat <= live_flags;

            if (stky_set)
                ps_stky_av <= 1'b1;
            else if (ps_stky_clr)
                ps_stky_av <= 1'b0;

            if (flag_pend & alu.alu_ps_compd)
                ps_cmp_hist <= {ps_cmp_hist[2*HIST_DEPTH-3:0], alu.alu_ps_an, alu.alu_ps_az};

            if (ps_mode_wr)
                sat_q <= ps_mode_din;
        end
    end

endmodule

// File: tb/tb_ps_alu_stat.sv
module tb_ps_alu_stat;
    import ps_alu_stat_pkg::*;

    localparam int HD = 4;

    logic          clk = 1'b0;
    logic          reset;
    logic          id_alu_vld;
    logic [5:0]    id_alu_op;
    logic          ps_stat_wr;
    logic [3:0]    ps_stat_din;
    logic          ps_mode_wr;
    logic          ps_mode_din;
    logic          ps_stky_clr;
    logic [3:0]    ps_cond_code;
    logic          ps_cond_true;
    logic [3:0]    ps_astat;
    logic          ps_stky_av;
    logic [2*HD-1:0] ps_cmp_hist;

    int n_checks = 0;
    int n_errs   = 0;

    ps_alu_stat_if alu_if ();

    ps_alu_stat #(.HIST_DEPTH(HD)) dut (
        .clk          (clk),
        .reset        (reset),
        .id_alu_vld   (id_alu_vld),
        .id_alu_op    (id_alu_op),
        .alu          (alu_if),
        .ps_stat_wr   (ps_stat_wr),
        .ps_stat_din  (ps_stat_din),
        .ps_mode_wr   (ps_mode_wr),
        .ps_mode_din  (ps_mode_din),
        .ps_stky_clr  (ps_stky_clr),
        .ps_cond_code (ps_cond_code),
        .ps_cond_true (ps_cond_true),
        .ps_astat     (ps_astat),
        .ps_stky_av   (ps_stky_av),
        .ps_cmp_hist  (ps_cmp_hist)
    );

    always #5 clk = ~clk;

    // Reference model: architectural state plus a log of issue cycles
    logic [3:0] m_astat;
    bit         m_stky;
    bit         m_sat;
    bit [1:0]   m_hist[$];   // front = newest {an, az}
    int         m_iss[$];    // cycles in which an instruction issued
    int         cyc;

    typedef struct {
        logic [3:0] din;
        logic [3:0] code;
        logic       exp;
    } cc_vec_t;
    cc_vec_t tbl[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errs++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic bit m_pend();
        return m_iss.size() > 0 && m_iss[m_iss.size()-1] == cyc - 1;
    endfunction

    function automatic logic [3:0] live();
        return {alu_if.alu_ps_av, alu_if.alu_ps_ac, alu_if.alu_ps_an, alu_if.alu_ps_az};
    endfunction

    function automatic logic [3:0] m_eff();
        return m_pend() ? live() : m_astat;
    endfunction

    // Truth vector indexed by condition code
    function automatic bit cc_truth(input logic [3:0] f, input logic [3:0] code);
        bit [15:0] tt;
        bit z, n, c, v;
        z = f[0]; n = f[1]; c = f[2]; v = f[3];
        tt = '0;
        tt[CC_EQ]  = z;       tt[CC_NE]  = !z;
        tt[CC_LT]  = n;       tt[CC_GE]  = !n;
        tt[CC_LE]  = n || z;  tt[CC_GT]  = !(n || z);
        tt[CC_AC]  = c;       tt[CC_NAC] = !c;
        tt[CC_AV]  = v;       tt[CC_NAV] = !v;
        tt[CC_TRUE] = 1'b1;
        return tt[code];
    endfunction

    function automatic logic [2*HD-1:0] m_hist_vec();
        logic [2*HD-1:0] e;
        e = '0;
        for (int i = 0; i < m_hist.size(); i++) e[2*i +: 2] = m_hist[i];
        return e;
    endfunction

    task automatic model_clock();
        bit p;
        if (reset) begin
            m_astat = '0; m_stky = 0; m_sat = 0;
            m_hist.delete(); m_iss.delete();
        end else begin
            p = m_pend();
            if (ps_stat_wr) m_astat = ps_stat_din;
            else if (p)     m_astat = live();
            if ((p && alu_if.alu_ps_av) || (ps_stat_wr && ps_stat_din[3])) m_stky = 1;
            else if (ps_stky_clr) m_stky = 0;
            if (p && alu_if.alu_ps_compd) begin
                m_hist.push_front({alu_if.alu_ps_an, alu_if.alu_ps_az});
                if (m_hist.size() > HD) void'(m_hist.pop_back());
            end
            if (ps_mode_wr) m_sat = ps_mode_din;
            if (id_alu_vld) m_iss.push_back(cyc);
            if (m_iss.size() > 4) void'(m_iss.pop_front());
        end
        cyc++;
    endtask

    task automatic check_comb();
        chk("m_en",   alu_if.ps_alu_en,  id_alu_vld);
        chk("m_log",  alu_if.ps_alu_log, id_alu_op[5]);
        chk("m_hc",   alu_if.ps_alu_hc,  id_alu_op[4:3]);
        chk("m_sc",   alu_if.ps_alu_sc,  id_alu_op[2:0]);
        chk("m_ci",   alu_if.ps_alu_ci,  m_eff()[2]);
        chk("m_cond", ps_cond_true,      cc_truth(m_eff(), ps_cond_code));
    endtask

    task automatic check_regs();
        chk("m_astat", ps_astat,          m_astat);
        chk("m_stky",  ps_stky_av,        m_stky);
        chk("m_hist",  ps_cmp_hist,       m_hist_vec());
        chk("m_sat",   alu_if.ps_alu_sat, m_sat);
    endtask

    // Inputs change at posedge+1; comb checked at +2, model stepped at the edge, regs at +1
    task automatic tick();
        #1 check_comb();
        @(posedge clk);
        model_clock();
        #1 check_regs();
    endtask

    task automatic set_flags(input bit z, input bit n, input bit c, input bit v, input bit cd);
        alu_if.alu_ps_az = z; alu_if.alu_ps_an = n; alu_if.alu_ps_ac = c;
        alu_if.alu_ps_av = v; alu_if.alu_ps_compd = cd;
    endtask

    task automatic quiet();
        reset = 0; id_alu_vld = 0; id_alu_op = '0; ps_stat_wr = 0; ps_stat_din = '0;
        ps_mode_wr = 0; ps_mode_din = 0; ps_stky_clr = 0; ps_cond_code = CC_FALSE;
        set_flags(0, 0, 0, 0, 0);
    endtask

    initial begin
        quiet();
        reset = 1;
        m_astat = '0; m_stky = 0; m_sat = 0; cyc = 0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_astat", ps_astat, 4'b0000);
        chk("rst_stky",  ps_stky_av, 1'b0);
        chk("rst_hist",  ps_cmp_hist, '0);
        chk("rst_sat",   alu_if.ps_alu_sat, 1'b0);
        reset = 0;
        ps_cond_code = CC_TRUE;
        #1 chk("rst_cc_true", ps_cond_true, 1'b1);
        ps_cond_code = CC_EQ;
        #1 chk("rst_cc_eq", ps_cond_true, 1'b0);
        tick();

        // Condition-code table: ASTAT written explicitly, no flags in flight
        tbl.push_back('{4'b0001, CC_EQ,  1'b1});
        tbl.push_back('{4'b0001, CC_NE,  1'b0});
        tbl.push_back('{4'b0001, CC_LE,  1'b1});
        tbl.push_back('{4'b0001, CC_GT,  1'b0});
        tbl.push_back('{4'b0010, CC_LT,  1'b1});
        tbl.push_back('{4'b0010, CC_GE,  1'b0});
        tbl.push_back('{4'b0010, CC_LE,  1'b1});
        tbl.push_back('{4'b0000, CC_GT,  1'b1});
        tbl.push_back('{4'b0000, CC_GE,  1'b1});
        tbl.push_back('{4'b0000, CC_EQ,  1'b0});
        tbl.push_back('{4'b0100, CC_AC,  1'b1});
        tbl.push_back('{4'b0100, CC_NAC, 1'b0});
        tbl.push_back('{4'b1000, CC_AV,  1'b1});
        tbl.push_back('{4'b1000, CC_NAV, 1'b0});
        tbl.push_back('{4'b0000, CC_TRUE, 1'b1});
        tbl.push_back('{4'b1111, CC_FALSE, 1'b0});
        tbl.push_back('{4'b1111, 4'd12,  1'b0});
        tbl.push_back('{4'b1111, 4'd15,  1'b0});
        foreach (tbl[i]) begin
            quiet();
            ps_stat_wr = 1; ps_stat_din = tbl[i].din;
            tick();
            ps_stat_wr = 0; ps_cond_code = tbl[i].code;
            #1 chk("cc_tbl", ps_cond_true, tbl[i].exp);
            chk("cc_tbl_astat", ps_astat, tbl[i].din);
            chk("cc_tbl_ci", alu_if.ps_alu_ci, tbl[i].din[2]);
        end

        // ADD: flags returned in N+1 visible in ASTAT at N+2
        quiet(); ps_stky_clr = 1; tick();
        quiet(); id_alu_vld = 1; id_alu_op = 6'b100001;
        #1 chk("iss_en", alu_if.ps_alu_en, 1'b1);
        chk("iss_log", alu_if.ps_alu_log, 1'b1);
        chk("iss_sc",  alu_if.ps_alu_sc, 3'b001);
        tick();
        id_alu_vld = 0; set_flags(0, 1, 0, 1, 0);
        tick();
        chk("add_astat", ps_astat, 4'b1010);
        chk("add_stky",  ps_stky_av, 1'b1);

        // Capture collides with an explicit write: the write wins, sticky still sets
        quiet(); ps_stky_clr = 1; tick();
        quiet(); id_alu_vld = 1; id_alu_op = 6'b000001; tick();
        id_alu_vld = 0; set_flags(0, 0, 1, 1, 0);
        ps_stat_wr = 1; ps_stat_din = 4'b0001;
        tick();
        chk("wr_prio_astat", ps_astat, 4'b0001);
        chk("wr_prio_stky",  ps_stky_av, 1'b1);

        // Three back-to-back COMPs
        quiet(); reset = 1; tick();
        quiet(); id_alu_vld = 1; id_alu_op = OP_COMP; tick();
        set_flags(0, 1, 0, 0, 1); tick();
        set_flags(1, 0, 0, 0, 1); tick();
        id_alu_vld = 0; set_flags(0, 0, 0, 0, 1); tick();
        chk("comp_hist", ps_cmp_hist[5:0], 6'b100100);

        // Carry-in forwarded from in-flight flags
        quiet(); ps_stat_wr = 1; ps_stat_din = 4'b0000; tick();
        quiet(); id_alu_vld = 1; id_alu_op = 6'b000001; tick();
        id_alu_op = 6'b000010; set_flags(0, 0, 1, 0, 0);
        #1 chk("fwd_ci", alu_if.ps_alu_ci, 1'b1);
        chk("fwd_astat_ac", ps_astat[ASTAT_AC], 1'b0);
        tick();

        // EQ evaluated on forwarded az
        quiet(); ps_stat_wr = 1; ps_stat_din = 4'b0000; tick();
        quiet(); id_alu_vld = 1; tick();
        id_alu_vld = 0; set_flags(1, 0, 0, 0, 0); ps_cond_code = CC_EQ;
        #1 chk("fwd_eq", ps_cond_true, 1'b1);
        chk("fwd_astat_az", ps_astat[ASTAT_AZ], 1'b0);
        tick();

        // Sticky set beats clear; clear alone works
        quiet(); id_alu_vld = 1; tick();
        id_alu_vld = 0; set_flags(0, 0, 0, 1, 0); ps_stky_clr = 1; tick();
        chk("stky_set_wins", ps_stky_av, 1'b1);
        set_flags(0, 0, 0, 0, 0); tick();
        chk("stky_clr", ps_stky_av, 1'b0);

        // Reset in the capture cycle discards the pending flags
        quiet(); ps_stat_wr = 1; ps_stat_din = 4'b0000; tick();
        quiet(); id_alu_vld = 1; tick();
        id_alu_vld = 0; set_flags(1, 1, 1, 1, 1); reset = 1; tick();
        chk("rst_pend_astat", ps_astat, 4'b0000);
        chk("rst_pend_stky",  ps_stky_av, 1'b0);

        // MODE1 write takes effect from the next cycle
        quiet(); ps_mode_wr = 1; ps_mode_din = 1;
        #1 chk("mode_before", alu_if.ps_alu_sat, 1'b0);
        tick();
        ps_mode_wr = 0;
        chk("mode_after", alu_if.ps_alu_sat, 1'b1);

        // Random traffic against the model
        quiet();
        for (int i = 0; i < 600; i++) begin
            reset        = ($urandom_range(0, 59) == 0);
            id_alu_vld   = $urandom_range(0, 1);
            id_alu_op    = 6'($urandom);
            set_flags($urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 1),
                      $urandom_range(0, 1), $urandom_range(0, 1));
            ps_stat_wr   = ($urandom_range(0, 3) == 0);
            ps_stat_din  = 4'($urandom);
            ps_mode_wr   = ($urandom_range(0, 7) == 0);
            ps_mode_din  = $urandom_range(0, 1);
            ps_stky_clr  = ($urandom_range(0, 5) == 0);
            ps_cond_code = 4'($urandom);
            tick();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errs);
        $finish;
    end

endmodule
